control_multi: RTL and testbench
================================

Name: control_multi

Overview:
- Multi-cycle MIPS control unit; the FSM-based successor to the single-cycle decoder, driving the shared-memory, shared-ALU datapath described in COD3e Section 5.5.
- Supports R-format, LW, SW, BEQ, BNE, ADDI and J.
- Adds parametrised memory wait-states, a textbook-subset mode, and a sticky illegal-opcode trap.
- Sits between the instruction register opcode field and all datapath mux selects and write enables.

Parameters:
- MEM_LATENCY, 1: cycles each memory access state is held. Legal range 1..15.
- CNT_W, 4: width of the wait-state counter. Must hold MEM_LATENCY-1.
- ENABLE_EXT, 1: when 1, BNE/ADDI/J are decoded. When 0, they trap as illegal (LW/SW/BEQ/R only).

Ports:
- clk in 1: rising-edge clock.
- reset in 1: synchronous, active-high reset.
- opcode in 6: IR[31:26]. Sampled in DECODE and MEMADR.
- PCWrite out 1: unconditional PC load.
- PCWriteCond out 1: PC load if ALU Zero (BEQ).
- PCWriteCondNE out 1: PC load if ALU not Zero (BNE).
- IorD out 1: memory address select (0 = PC, 1 = ALUOut).
- MemRead out 1: memory read enable.
- MemWrite out 1: memory write enable.
- IRWrite out 1: instruction register load.
- MemtoReg out 1: register write data select (1 = MDR).
- RegDst out 1: destination register select (1 = rd, 0 = rt).
- RegWrite out 1: register file write enable.
- ALUSrcA out 1: ALU A select (0 = PC, 1 = A).
- ALUSrcB out 2: ALU B select (00 = B, 01 = 4, 10 = SignExt, 11 = SignExt<<2).
- ALUOp out 2: 00 = add, 01 = sub, 10 = funct.
- PCSource out 2: 00 = ALU, 01 = ALUOut, 10 = jump target.
- state out 4: current state encoding, for debug and bench.
- illegal_op out 1: high while in ERROR.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11, BNE=12, ERROR=13. Codes 14 and 15 go to ERROR.
- State and counter are registered. All outputs decode from the state plus a last-cycle flag.
- Every output not listed for a state is 0. No x values are ever driven.
- last = (cnt == MEM_LATENCY-1).
  - cnt increments while in FETCH, MEMRD or MEMWR and not last.
  - cnt clears to 0 on every state transition, and in all other states.
  - A wait-state holds its outputs constant for all MEM_LATENCY cycles, then advances.
- State outputs and transitions:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=1 and PCWrite=1 only when last. When last, go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Dispatch on opcode:
    - 0 -> EXEC
    - 35 or 43 -> MEMADR
    - 4 -> BEQ
    - 5 -> BNE (ext)
    - 8 -> ADDIEX (ext)
    - 2 -> JUMP (ext)
    - anything else -> ERROR. An ext opcode with ENABLE_EXT=0 also goes to ERROR.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Opcode 35 -> MEMRD, otherwise -> MEMWR.
  - MEMRD: MemRead=1, IorD=1. When last, go to MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
  - MEMWR: MemWrite=1, IorD=1, held high all MEM_LATENCY cycles. When last, go to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
  - RWB: RegDst=1, RegWrite=1, MemtoReg=0 -> FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 -> FETCH.
  - BNE: as BEQ, but PCWriteCondNE=1 instead of PCWriteCond -> FETCH.
  - JUMP: PCWrite=1, PCSource=10 -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB: RegDst=0, RegWrite=1, MemtoReg=0 -> FETCH.
  - ERROR: all controls 0, illegal_op=1. Sticky; only reset exits.
- Latency in cycles, with L = MEM_LATENCY: R = L+3, LW = 2L+3, SW = 2L+2, BEQ/BNE = L+2, J = L+2, ADDI = L+3.
- Reset:
  - On a clock edge with reset=1: state <= FETCH, cnt <= 0.
  - Reset has priority over all transitions, including mid-wait and in ERROR.
  - Outputs after reset are the FETCH values above: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=(MEM_LATENCY==1), illegal_op=0, all others 0.
- Opcode changes outside DECODE and MEMADR have no effect.

Test Plan:
- MEM_LATENCY=1, opcode 0 after reset -> states 0,1,6,7,0. RegWrite=1 and RegDst=1 in cycle 4 only. IRWrite=1 in cycle 1 only.
- MEM_LATENCY=3, LW (35) -> state 0 for 3 cycles (IRWrite high only on the 3rd), then 1, 2, then 3 for 3 cycles with IorD=1, then 4 with MemtoReg=1. Total 9 cycles.
- MEM_LATENCY=2, SW (43) then BNE (5) -> MemWrite high for exactly 2 cycles. BNE state 12 asserts PCWriteCondNE=1, PCWriteCond=0, ALUOp=01.
- ENABLE_EXT=0, opcode 8 -> ERROR (13) after DECODE, illegal_op=1 and all controls 0 for 20 cycles. Then reset -> FETCH.
- Opcode 63 in DECODE -> ERROR. With ENABLE_EXT=1, J (2) -> PCWrite=1 and PCSource=10 in state 9. ADDI (8) -> states 10, 11 with ALUSrcB=10, RegWrite=1, RegDst=0.
- MEM_LATENCY=4, reset asserted in the 2nd cycle of MEMRD -> next state FETCH with cnt=0. IRWrite first asserts 4 cycles later.

Source files
------------

// File: rtl/control_multi.sv
// Multi-cycle MIPS control FSM: sequences the shared-memory/shared-ALU datapath,
// stretches memory states by MEM_LATENCY cycles and traps illegal opcodes stickily.
module control_multi #(
    parameter int MEM_LATENCY = 1,
    parameter int CNT_W       = 4,
    parameter bit ENABLE_EXT  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal_op
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_BNE    = 4'd12,
        S_ERROR  = 4'd13
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last;
    logic             wait_state;

    assign last       = (cnt_reg == LAST_CNT);
    assign wait_state = (state_reg == S_FETCH) || (state_reg == S_MEMRD) || (state_reg == S_MEMWR);
    assign state      = state_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
        end else begin
            // Wait-states count up until last; any transition or other state clears the counter
            cnt_reg <= (wait_state && !last) ? cnt_reg + CNT_W'(1) : '0;
            case (state_reg)
                S_FETCH:  if (last) state_reg <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        6'd0:        state_reg <= S_EXEC;
                        6'd35, 6'd43: state_reg <= S_MEMADR;
                        6'd4:        state_reg <= S_BEQ;
                        6'd5:        state_reg <= ENABLE_EXT ? S_BNE    : S_ERROR;
                        6'd8:        state_reg <= ENABLE_EXT ? S_ADDIEX : S_ERROR;
                        6'd2:        state_reg <= ENABLE_EXT ? S_JUMP   : S_ERROR;
                        default:     state_reg <= S_ERROR;
                    endcase
                end
                S_MEMADR: state_reg <= (opcode == 6'd35) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (last) state_reg <= S_MEMWB;
                S_MEMWR:  if (last) state_reg <= S_FETCH;
                S_EXEC:   state_reg <= S_RWB;
                S_ADDIEX: state_reg <= S_ADDIWB;
                S_MEMWB, S_RWB, S_BEQ, S_BNE, S_JUMP, S_ADDIWB: state_reg <= S_FETCH;
                default:  state_reg <= S_ERROR;
            endcase
        end
    end

    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNE = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemtoReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        PCSource      = 2'b00;
        illegal_op    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC load once, on the final cycle of the fetch wait
                IRWrite = last;
                PCWrite = last;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 2'b01;
                PCSource      = 2'b01;
                PCWriteCond   = (state_reg == S_BEQ);
                PCWriteCondNE = (state_reg == S_BNE);
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_ERROR:  illegal_op = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_multi.sv
// Bench for control_multi: four instances with different latency/extension settings
// share one opcode/reset stream and are each compared to a queue-of-states model.
`timescale 1ns/1ps
module tb_control_multi;
    localparam int NDUT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [5:0] opcode;
    logic [17:0] ctl [NDUT];
    logic [3:0]  st  [NDUT];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            localparam int LAT = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 2 : 4;
            localparam bit EXT = (gi == 2) ? 1'b0 : 1'b1;
            logic pcw, pcc, pcne, iord, mr, mw, irw, m2r, rd, rw, sa, il;
            logic [1:0] sb, aop, ps;
            logic [3:0] s;
            control_multi #(.MEM_LATENCY(LAT), .CNT_W(4), .ENABLE_EXT(EXT)) u_dut (
                .clk(clk), .reset(reset), .opcode(opcode),
                .PCWrite(pcw), .PCWriteCond(pcc), .PCWriteCondNE(pcne),
                .IorD(iord), .MemRead(mr), .MemWrite(mw), .IRWrite(irw),
                .MemtoReg(m2r), .RegDst(rd), .RegWrite(rw), .ALUSrcA(sa),
                .ALUSrcB(sb), .ALUOp(aop), .PCSource(ps), .state(s), .illegal_op(il)
            );
            assign ctl[gi] = {pcw, pcc, pcne, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, il};
            assign st[gi]  = s;
        end
    endgenerate

    // Reference model: per instance, the list of states still to visit for the current instruction
    logic [3:0] q_st   [NDUT][64];
    bit         q_last [NDUT][64];
    int         hd [NDUT];
    int         tl [NDUT];
    logic [5:0] legal [7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd2};

    function automatic int lat_of(input int d);
        case (d)
            0: return 1;
            1: return 3;
            2: return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit ext_of(input int d);
        return d != 2;
    endfunction

    task automatic push(input int d, input logic [3:0] s, input bit lst);
        q_st[d][tl[d]]   = s;
        q_last[d][tl[d]] = lst;
        tl[d]++;
    endtask

    task automatic push_wait(input int d, input logic [3:0] s);
        for (int k = 0; k < lat_of(d); k++) push(d, s, k == lat_of(d) - 1);
    endtask

    task automatic model_edge(input int d, input bit rst, input logic [5:0] op);
        logic [3:0] cur;
        if (rst) begin
            hd[d] = 0;
            tl[d] = 0;
        end else begin
            cur = q_st[d][hd[d]];
            hd[d]++;
            if (hd[d] == tl[d]) begin
                hd[d] = 0;
                tl[d] = 0;
            end
            if (cur == 4'd1) begin
                if (op == 6'd0) begin push(d, 4'd6, 1'b1); push(d, 4'd7, 1'b1); end
                else if (op == 6'd35 || op == 6'd43) push(d, 4'd2, 1'b1);
                else if (op == 6'd4) push(d, 4'd8, 1'b1);
                else if (op == 6'd5 && ext_of(d)) push(d, 4'd12, 1'b1);
                else if (op == 6'd8 && ext_of(d)) begin push(d, 4'd10, 1'b1); push(d, 4'd11, 1'b1); end
                else if (op == 6'd2 && ext_of(d)) push(d, 4'd9, 1'b1);
                else push(d, 4'd13, 1'b1);
            end else if (cur == 4'd2) begin
                if (op == 6'd35) begin push_wait(d, 4'd3); push(d, 4'd4, 1'b1); end
                else push_wait(d, 4'd5);
            end else if (cur == 4'd13) begin
                push(d, 4'd13, 1'b1);
            end
        end
        if (tl[d] == 0) begin
            push_wait(d, 4'd0);
            push(d, 4'd1, 1'b1);
        end
    endtask

    function automatic logic [17:0] exp_ctl(input logic [3:0] s, input bit lst);
        logic pcw, pcc, pcne, iord, mr, mw, irw, m2r, rd, rw, sa, il;
        logic [1:0] sb, aop, ps;
        {pcw, pcc, pcne, iord, mr, mw, irw, m2r, rd, rw, sa, il} = '0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (s)
            4'd0:  begin mr = 1; sb = 2'b01; irw = lst; pcw = lst; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mr = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; iord = 1; end
            4'd6:  begin sa = 1; aop = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin sa = 1; aop = 2'b01; pcc = 1; ps = 2'b01; end
            4'd9:  begin pcw = 1; ps = 2'b10; end
            4'd10: begin sa = 1; sb = 2'b10; end
            4'd11: rw = 1;
            4'd12: begin sa = 1; aop = 2'b01; pcne = 1; ps = 2'b01; end
            4'd13: il = 1;
            default: ;
        endcase
        return {pcw, pcc, pcne, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, il};
    endfunction

    task automatic step(input bit rst, input logic [5:0] op);
        logic [3:0]  es;
        logic [17:0] ec;
        reset  = rst;
        opcode = op;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            model_edge(d, rst, op);
            es = q_st[d][hd[d]];
            ec = exp_ctl(es, q_last[d][hd[d]]);
            n_tests++;
            assert (st[d] === es) else begin
                n_fail++;
                $error("FAIL state dut%0d cyc%0d got %0d expected %0d", d, cyc, st[d], es);
            end
            n_tests++;
            assert (ctl[d] === ec) else begin
                n_fail++;
                $error("FAIL ctl dut%0d cyc%0d state %0d got %b expected %b", d, cyc, st[d], ctl[d], ec);
            end
        end
    endtask

    initial begin
        int n;
        int in_rd;
        bit rst;
        logic [5:0] op;
        for (int d = 0; d < NDUT; d++) begin hd[d] = 0; tl[d] = 0; end

        step(1'b1, 6'd0);
        step(1'b1, 6'd0);
        n_tests++;
        assert (ctl[0][11] === 1'b1 && ctl[3][11] === 1'b0) else begin
            n_fail++;
            $error("FAIL reset_irwrite got %b/%b expected 1/0", ctl[0][11], ctl[3][11]);
        end

        for (int i = 0; i < 12; i++) step(1'b0, 6'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 6'd35);
        for (int i = 0; i < 20; i++) step(1'b0, 6'd43);
        for (int i = 0; i < 15; i++) step(1'b0, 6'd5);
        for (int i = 0; i < 15; i++) step(1'b0, 6'd4);
        for (int i = 0; i < 15; i++) step(1'b0, 6'd2);
        for (int i = 0; i < 40; i++) step(1'b0, 6'd8);
        n_tests++;
        assert (st[2] === 4'd13 && ctl[2] === 18'd1) else begin
            n_fail++;
            $error("FAIL noext_trap got state %0d ctl %b expected 13 / 1", st[2], ctl[2]);
        end

        for (int i = 0; i < 12; i++) step(1'b0, 6'd63);
        n_tests++;
        assert (st[0] === 4'd13 && st[3] === 4'd13) else begin
            n_fail++;
            $error("FAIL illegal_trap got %0d/%0d expected 13/13", st[0], st[3]);
        end
        step(1'b1, 6'd63);
        n_tests++;
        assert (st[0] === 4'd0 && st[1] === 4'd0 && st[2] === 4'd0 && st[3] === 4'd0) else begin
            n_fail++;
            $error("FAIL error_reset got %0d %0d %0d %0d expected all 0", st[0], st[1], st[2], st[3]);
        end

        // Reset dut3 (latency 4) during its second MEMRD cycle
        n = 0;
        in_rd = 0;
        while (in_rd < 2 && n < 200) begin
            step(1'b0, 6'd35);
            n++;
            if (st[3] == 4'd3) in_rd++;
        end
        n_tests++;
        assert (in_rd == 2) else begin
            n_fail++;
            $error("FAIL memrd_wait timeout got %0d cycles in MEMRD expected 2", in_rd);
        end
        step(1'b1, 6'd35);
        n = 1;
        while (ctl[3][11] !== 1'b1 && n < 20) begin
            step(1'b0, 6'd35);
            n++;
        end
        n_tests++;
        assert (n == 4) else begin
            n_fail++;
            $error("FAIL irwrite_after_reset got cycle %0d expected 4", n);
        end

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) < 3);
            op  = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 6)] : 6'($urandom);
            step(rst, op);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
